// File: rtl/axis_cobs_decoder.sv
// axis_cobs_decoder
//   COBS frame decoder for a byte-wide AXI-Stream. A 0x00 byte delimits frames.
//   Each decoded frame leaves as an AXIS packet. tlast marks the last byte.
//   tuser is set on the tlast beat when the frame was malformed or truncated.
//
// Ports
//   clk, reset     single clock; asynchronous active-high reset
//   s_axis_*       COBS-encoded input bytes (tlast ignored)
//   m_axis_*       decoded payload bytes; tuser valid on the tlast beat only
//   frame_error    one-cycle pulse per detected error (premature delimiter, overflow)
module axis_cobs_decoder #(
    parameter int MAX_FRAME_LEN = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       frame_error
);
    localparam int CW = $clog2(MAX_FRAME_LEN + 1);

    typedef enum logic [1:0] {CODE, DATA, DISCARD} state_t;

    state_t          state;
    logic [7:0]      la_data;
    logic            la_valid;
    logic            pending_zero;
    logic            blk_zero;
    logic [7:0]      remain;
    logic [CW-1:0]   count;

    // Framing comes only from delimiters, so input tlast is deliberately unused.
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;

    // An input byte produces at most one output beat, so a free (or draining)
    // output register is all that is needed to accept it.
    assign s_axis_tready = !reset && (!m_axis_tvalid || m_axis_tready);

    logic       s_fire;
    logic       do_push;
    logic [7:0] push_byte;
    logic       end_frame;
    logic       bad;
    logic       overflow;

    always_comb begin
        s_fire    = s_axis_tvalid && s_axis_tready;
        do_push   = 1'b0;
        push_byte = 8'h00;
        end_frame = 1'b0;
        bad       = 1'b0;
        unique case (state)
            CODE: begin
                if (s_axis_tdata == 8'h00) end_frame = 1'b1;
                else if (pending_zero)     do_push   = 1'b1;  // implicit zero of previous block
            end
            DATA: begin
                if (s_axis_tdata == 8'h00) begin
                    end_frame = 1'b1;
                    bad       = 1'b1;
                end else begin
                    do_push   = 1'b1;
                    push_byte = s_axis_tdata;
                end
            end
            default: begin
                if (s_axis_tdata == 8'h00) end_frame = 1'b1;  // la is empty here
            end
        endcase
        overflow = do_push && (count == CW'(MAX_FRAME_LEN));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= CODE;
            la_data       <= 8'h00;
            la_valid      <= 1'b0;
            pending_zero  <= 1'b0;
            blk_zero      <= 1'b0;
            remain        <= 8'h00;
            count         <= '0;
            m_axis_tdata  <= 8'h00;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;

            if (s_fire) begin
                // Datapath: flush lookahead as the frame's last beat, or shift it out.
                if (end_frame || overflow) begin
                    if (la_valid) begin
                        m_axis_tdata  <= la_data;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b1;
                        m_axis_tuser  <= bad || overflow;
                    end
                    la_valid    <= 1'b0;
                    frame_error <= bad || overflow;
                end else if (do_push) begin
                    if (la_valid) begin
                        m_axis_tdata  <= la_data;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tuser  <= 1'b0;
                    end
                    la_data  <= push_byte;
                    la_valid <= 1'b1;
                    count    <= count + 1'b1;  // overflow excluded, so never wraps
                end

                // Control
                if (end_frame) begin
                    state        <= CODE;
                    pending_zero <= 1'b0;  // trailing implicit zero is dropped
                    count        <= '0;
                end else if (overflow) begin
                    state        <= DISCARD;
                    pending_zero <= 1'b0;
                end else begin
                    unique case (state)
                        CODE: begin
                            remain       <= s_axis_tdata - 8'd1;
                            blk_zero     <= (s_axis_tdata != 8'hFF);
                            pending_zero <= (s_axis_tdata == 8'h01);
                            if (s_axis_tdata != 8'h01) state <= DATA;
                        end
                        DATA: begin
                            remain <= remain - 8'd1;
                            if (remain == 8'd1) begin
                                pending_zero <= blk_zero;
                                state        <= CODE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule
